// File: rtl/alu_pkg.sv
// Op codes shared by alu_control and the execute-stage ALU, so the two decoders stay in step.
package alu_pkg;
    localparam int ALU_CTRL_W = 4;

    typedef logic [ALU_CTRL_W-1:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'd0;
    localparam alu_op_t ALU_OR   = 4'd1;
    localparam alu_op_t ALU_ADD  = 4'd2;
    localparam alu_op_t ALU_SLL  = 4'd3;
    localparam alu_op_t ALU_SRL  = 4'd4;
    localparam alu_op_t ALU_SUB  = 4'd5;
    localparam alu_op_t ALU_MULT = 4'd6;
    localparam alu_op_t ALU_SLT  = 4'd7;
    localparam alu_op_t ALU_NOR  = 4'd12;

    function automatic logic is_known_op(input alu_op_t op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL,
            ALU_SUB, ALU_MULT, ALU_SLT, ALU_NOR: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/mult_iter.sv
// Iterative signed multiplier: magnitudes are multiplied one bit per cycle, sign applied at the end.
// state   | meaning
// ST_IDLE | waiting for start, busy=0
// ST_MUL  | one shift-add iteration per cycle, cnt counts iterations done
module mult_iter import alu_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]          state;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                neg;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] mag;
    logic                last;

    // |MIN| = 2^(DATA_W-1) still fits once the value is treated as unsigned
    function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
        mag     = {sum[DATA_W:1], sum[0], lo[DATA_W-1:1]};
        product = neg ? (~mag + (2*DATA_W)'(1)) : mag;
        last    = (state == ST_MUL) && (cnt == CNT_W'(DATA_W-1));
        done    = last && !flush;
        busy    = (state == ST_MUL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        mcand <= mag_of(a);
                        lo    <= mag_of(b);
                        hi    <= '0;
                        neg   <= a[DATA_W-1] ^ b[DATA_W-1];
                        cnt   <= '0;
                        state <= ST_MUL;
                    end
                end
                default: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        hi  <= sum[DATA_W:1];
                        lo  <= {sum[0], lo[DATA_W-1:1]};
                        cnt <= cnt + CNT_W'(1);
                        if (last) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops registered in one cycle, MULT handed to mult_iter
// with in_ready held low until the product is registered.
module alu_multicycle import alu_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [4:0]            shamt,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     result,
    output logic [DATA_W-1:0]     result_hi,
    output logic                  zero,
    output logic                  overflow
);
    logic                accept;
    logic                is_mult;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic [DATA_W-1:0]   sum_ab;
    logic [DATA_W-1:0]   diff_ab;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_ovf;
    logic                alu_known;

    assign in_ready = !mul_busy;
    assign accept   = in_valid && in_ready && !flush;
    assign is_mult  = (alu_control == ALU_MULT);

    mult_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mult),
        .flush   (flush),
        .a       (operand_a),
        .b       (operand_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum_ab    = operand_a + operand_b;
        diff_ab   = operand_a - operand_b;
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_known = is_known_op(alu_control);
        case (alu_control)
            ALU_AND: alu_res = operand_a & operand_b;
            ALU_OR:  alu_res = operand_a | operand_b;
            ALU_ADD: begin
                alu_res = sum_ab;
                alu_ovf = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                          (sum_ab[DATA_W-1] != operand_a[DATA_W-1]);
            end
            ALU_SLL: alu_res = operand_b << shamt;
            ALU_SRL: alu_res = operand_b >> shamt;
            ALU_SUB: begin
                alu_res = diff_ab;
                alu_ovf = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                          (diff_ab[DATA_W-1] != operand_a[DATA_W-1]);
            end
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_NOR: alu_res = ~(operand_a | operand_b);
            default: alu_res = '0;
        endcase
    end

    // Outputs only move on a result; they hold across idle cycles and flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_product[DATA_W-1:0];
            result_hi <= mul_product[2*DATA_W-1:DATA_W];
            zero      <= (mul_product[DATA_W-1:0] == '0);
            overflow  <= 1'b0;
        end else if (accept && !is_mult) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            result_hi <= '0;
            zero      <= alu_known && (alu_res == '0);
            overflow  <= alu_ovf;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: constant vector table, directed multi-cycle sequences, and
// random ops checked against a plain-arithmetic reference model.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  shamt = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    always #5 clk = ~clk;

    alu_multicycle #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .shamt       (shamt),
        .flush       (flush),
        .out_valid   (out_valid),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        v;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        res_t        e;
    } vec_t;

    vec_t vecs[$];

    function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        res_t   r;
        longint s;
        longint p;
        bit     known;
        r.lo = '0; r.hi = '0; r.z = 1'b0; r.v = 1'b0;
        known = 1'b1;
        case (op)
            4'd0:  r.lo = a & b;
            4'd1:  r.lo = a | b;
            4'd2: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r.lo = s[31:0];
                r.v  = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            4'd3:  r.lo = b << sh;
            4'd4:  r.lo = b >> sh;
            4'd5: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r.lo = s[31:0];
                r.v  = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            4'd6: begin
                p = longint'($signed(a)) * longint'($signed(b));
                r.lo = p[31:0];
                r.hi = p[63:32];
            end
            4'd7:  r.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: r.lo = ~(a | b);
            default: known = 1'b0;
        endcase
        r.z = known && (r.lo == 32'd0);
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] lo, input logic [31:0] hi,
                                input logic z, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.sh = sh;
        t.e.lo = lo; t.e.hi = hi; t.e.z = z; t.e.v = v;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input res_t e);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " result"},    64'(result),    64'(e.lo));
        chk({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
        chk({tag, " zero"},      64'(zero),      64'(e.z));
        chk({tag, " overflow"},  64'(overflow),  64'(e.v));
        last_lo = e.lo;
        last_hi = e.hi;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        alu_control = op; operand_a = a; operand_b = b; shamt = sh;
    endtask

    // Entered and left just after a falling edge
    task automatic do_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh, input res_t e);
        drive(op, a, b, sh);
        in_valid = 1'b1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_out(tag, e);
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input res_t e);
        int lat;
        int low;
        drive(4'd6, a, b, 5'd0);
        in_valid = 1'b1;
        @(negedge clk);
        if (hold) drive(4'd2, 32'd1, 32'd1, 5'd0);
        else in_valid = 1'b0;
        lat = 0;
        low = 0;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            if (!in_ready) low++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'd33);
        chk({tag, " ready_low_cycles"}, 64'(low), 64'd32);
        chk({tag, " in_ready_at_out"}, 64'(in_ready), 64'd1);
        check_out(tag, e);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int    seen;
        res_t  e;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;

        vecs.push_back(mk(4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(4'd5,  32'd5,         32'd5,         5'd0,  32'h0000_0000, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(4'd6,  32'hFFFF_FFFD, 32'd7,         5'd0,  32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(4'd6,  32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000, 32'h4000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(4'd7,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'h0000_0001, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd3,  32'h0,         32'd1,         5'd31, 32'h8000_0000, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd4,  32'h0,         32'h8000_0000, 5'd31, 32'h0000_0001, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd12, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd9,  32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  32'h0000_0000, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd5,  32'h8000_0000, 32'd1,         5'd0,  32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(4'd2,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'h0000_0000, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd1,  32'hF0F0_0000, 32'h0000_0F0F, 5'd0,  32'hF0F0_0F0F, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'd7,  32'd1,         32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 32'h0, 1'b1, 1'b0));

        // Reset
        repeat (2) @(negedge clk);
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result",    64'(result),    64'd0);
        chk("reset result_hi", 64'(result_hi), 64'd0);
        chk("reset zero",      64'(zero),      64'd0);
        chk("reset overflow",  64'(overflow),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Constant table, applied back to back; MULT entries hold in_valid during MUL
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].op == 4'd6)
                do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b1, vecs[i].e);
            else
                do_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].e);
        end

        // Outputs hold once the pulse ends
        @(negedge clk);
        chk("hold out_valid", 64'(out_valid), 64'd0);
        chk("hold result",    64'(result),    64'(last_lo));

        // Flush at iteration 10
        drive(4'd6, 32'hFFFF_FFFB, 32'd9, 5'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush busy before", 64'(in_ready), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush in_ready",  64'(in_ready),  64'd1);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush result",    64'(result),    64'(last_lo));
        chk("flush result_hi", 64'(result_hi), 64'(last_hi));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush no late out_valid", 64'(seen), 64'd0);

        // Flush and request together in IDLE: nothing accepted
        drive(4'd2, 32'd1, 32'd2, 5'd0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush+valid out_valid", 64'(out_valid), 64'd0);
        chk("flush+valid result",    64'(result),    64'(last_lo));
        do_single("after flush", 4'd2, 32'd1, 32'd2, 5'd0, model(4'd2, 32'd1, 32'd2, 5'd0));

        // Reset at iteration 20
        drive(4'd6, 32'h1234_5678, 32'h0000_0123, 5'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready",  64'(in_ready),  64'd1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst result",    64'(result),    64'd0);
        chk("midrst result_hi", 64'(result_hi), 64'd0);
        chk("midrst zero",      64'(zero),      64'd0);
        chk("midrst overflow",  64'(overflow),  64'd0);
        last_lo = '0;
        last_hi = '0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst no late out_valid", 64'(seen), 64'd0);

        // Random ops against the reference model
        for (int i = 0; i < 160; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = pick();
            sh = 5'($urandom_range(0, 31));
            e  = model(op, a, b, sh);
            if (op == 4'd6) do_mult($sformatf("rnd%0d mult", i), a, b, 1'b0, e);
            else            do_single($sformatf("rnd%0d op%0d", i, op), op, a, b, sh, e);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk($sformatf("rnd%0d idle out_valid", i), 64'(out_valid), 64'd0);
                chk($sformatf("rnd%0d idle result", i),    64'(result),    64'(last_lo));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
